// File: rtl/mul_arb_pkg.sv
// Shared constants and the tag type for the round-robin multiplier arbiter.
package mul_arb_pkg;
    localparam int MUL_LAT_DEF = 5;
    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
    // Sized for the largest supported requester count (8).
    localparam int TAG_ID_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;
endpackage

// File: rtl/karatsuba_multiply_32.sv
// Five-stage pipelined 32x32 unsigned Karatsuba multiplier; datapath has no reset.
module karatsuba_multiply_32
    import mul_arb_pkg::*;
(
    input  logic              clk,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] p_o
);
    logic [31:0] a1_q, b1_q;
    logic [31:0] hh2_q, ll2_q;
    logic [16:0] sa2_q, sb2_q;
    logic [31:0] hh3_q, ll3_q;
    logic [33:0] mm3_q;
    logic [31:0] hh4_q, ll4_q;
    logic [33:0] mid4_q;
    logic [63:0] p5_q;

    always_ff @(posedge clk) begin
        a1_q   <= a_i;
        b1_q   <= b_i;
        hh2_q  <= {16'd0, a1_q[31:16]} * {16'd0, b1_q[31:16]};
        ll2_q  <= {16'd0, a1_q[15:0]} * {16'd0, b1_q[15:0]};
        sa2_q  <= {1'b0, a1_q[31:16]} + {1'b0, a1_q[15:0]};
        sb2_q  <= {1'b0, b1_q[31:16]} + {1'b0, b1_q[15:0]};
        hh3_q  <= hh2_q;
        ll3_q  <= ll2_q;
        mm3_q  <= {17'd0, sa2_q} * {17'd0, sb2_q};
        hh4_q  <= hh3_q;
        ll4_q  <= ll3_q;
        // Middle term (ah+al)(bh+bl) - ah*bh - al*bl is always non-negative.
        mid4_q <= mm3_q - {2'd0, hh3_q} - {2'd0, ll3_q};
        p5_q   <= {hh4_q, ll4_q} + {14'd0, mid4_q, 16'd0};
    end

    assign p_o = p5_q;
endmodule

// File: rtl/mul_arbiter_rr.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Optional per-requester grant counters are enabled by defining MUL_ARB_STATS_EN.
module mul_arbiter_rr
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_x,
    input  logic [NUM_REQ*OP_W-1:0] req_y,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [PROD_W-1:0]       resp_product,
    output logic                    busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]   grant_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_oh;
    logic [PTR_W-1:0]  grant_id;
    logic [PTR_W:0]    cand;
    logic              accept;
    logic [OP_W-1:0]   mul_x, mul_y;
    logic [PROD_W-1:0] mul_p;
    mul_tag_t          tag_q [MUL_LAT];
    mul_tag_t          tail;

    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ))
                cand = cand - (PTR_W+1)'(NUM_REQ);
            if (arb_en && (grant_oh == '0) && req_valid[cand[PTR_W-1:0]]) begin
                grant_oh[cand[PTR_W-1:0]] = 1'b1;
                grant_id                  = cand[PTR_W-1:0];
            end
        end
    end

    assign accept    = |grant_oh;
    assign req_ready = grant_oh;

    always_comb begin
        ptr_d = ptr_q;
        if (accept)
            ptr_d = (grant_id == PTR_W'(NUM_REQ-1)) ? '0 : grant_id + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // One-hot grant makes an AND-OR mux; idle cycles feed zeros.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mul_x = mul_x | (req_x[i*OP_W +: OP_W] & {OP_W{grant_oh[i]}});
            mul_y = mul_y | (req_y[i*OP_W +: OP_W] & {OP_W{grant_oh[i]}});
        end
    end

    karatsuba_multiply_32 u_mul (
        .clk (clk),
        .a_i (mul_x),
        .b_i (mul_y),
        .p_o (mul_p)
    );

    generate
        for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_q[gi] <= '0;
                end else if (gi == 0) begin
                    tag_q[gi].valid <= accept;
                    tag_q[gi].id    <= TAG_ID_W'(grant_id);
                end else begin
                    tag_q[gi] <= tag_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MUL_LAT; s++)
            busy = busy | tag_q[s].valid;
    end

    assign tail = tag_q[MUL_LAT-1];

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            resp_valid[i] = tail.valid && (tail.id == TAG_ID_W'(i));
    end

    assign resp_product = tail.valid ? mul_p : '0;

`ifdef MUL_ARB_STATS_EN
    logic [31:0] cnt_q [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           cnt_q[gi] <= '0;
                else if (grant_oh[gi]) cnt_q[gi] <= cnt_q[gi] + 32'd1;
            end
            assign grant_cnt[gi*32 +: 32] = cnt_q[gi];
        end
    endgenerate
`endif
endmodule

// File: tb/tb_mul_arbiter_rr.sv
// Directed bench for mul_arbiter_rr with a cycle-level reference model and literal pins.
module tb_mul_arbiter_rr;
    localparam int N   = 4;
    localparam int LAT = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arb_en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_x = '0;
    logic [N*32-1:0] req_y = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [63:0]     resp_product;
    logic            busy;
`ifdef MUL_ARB_STATS_EN
    logic [N*32-1:0] grant_cnt;
`endif

    mul_arbiter_rr #(.NUM_REQ(N), .MUL_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_product (resp_product),
        .busy         (busy)
`ifdef MUL_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model: outstanding operations kept as {due cycle, id, product}.
    typedef struct {
        int          due;
        int          id;
        logic [63:0] p;
    } op_t;
    op_t m_q[$];
    int  m_ptr = 0;
    bit  model_on = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_rv;
        logic [63:0]  e_p;
        logic         e_busy;
        int           g, idx;
        op_t          o;
        e_ready = '0; e_rv = '0; e_p = '0; e_busy = 1'b0; g = -1;
        if (model_on) begin
            if (!rst_n) begin
                m_q.delete();
                m_ptr = 0;
            end else begin
                if (arb_en)
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (g < 0 && req_valid[idx]) g = idx;
                    end
                if (g >= 0) e_ready[g] = 1'b1;
                foreach (m_q[i]) begin
                    e_busy = 1'b1;
                    if (m_q[i].due == cyc) begin
                        e_rv[m_q[i].id] = 1'b1;
                        e_p = m_q[i].p;
                    end
                end
            end
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("resp_product", resp_product, e_p);
            chk("busy", 64'(busy), 64'(e_busy));
            if (rst_n) begin
                while (m_q.size() > 0 && m_q[0].due <= cyc) void'(m_q.pop_front());
                if (g >= 0) begin
                    o.due = cyc + LAT;
                    o.id  = g;
                    o.p   = {32'd0, req_x[g*32 +: 32]} * {32'd0, req_y[g*32 +: 32]};
                    m_q.push_back(o);
                    m_ptr = (g + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [N-1:0] v);
        arb_en    = en;
        req_valid = v;
    endtask

    task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
        req_x[i*32 +: 32] = x;
        req_y[i*32 +: 32] = y;
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    int gr[8];
    int rs[8];
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        model_on = 1'b1;
        #1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;

        // Single operation 3*5 from requester 0.
        set_op(0, 32'd3, 32'd5);
        drive(1'b1, 4'b0001);
        @(negedge clk);
        chk("s1_ready", 64'(req_ready), 64'h1);
        tick();
        drive(1'b1, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("s1_busy", 64'(busy), 64'd1);
            if (k == 5) begin
                chk("s1_resp_valid", 64'(resp_valid), 64'h1);
                chk("s1_product", resp_product, 64'd15);
            end
            tick();
        end
        @(negedge clk);
        chk("s1_busy_low", 64'(busy), 64'd0);
        tick();

        // All four requesters valid for eight cycles.
        pulse_reset(2);
        for (int i = 0; i < N; i++) set_op(i, 32'(i * 1000 + 7), 32'(i + 11));
        for (int c = 0; c < 13; c++) begin
            drive(1'b1, (c < 8) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            if (c < 8)  gr[c]     = oh_idx(req_ready);
            if (c >= 5) rs[c - 5] = oh_idx(resp_valid);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            chk("s2_grant_order", 64'(gr[i]), 64'(exp_seq[i]));
            chk("s2_resp_order", 64'(rs[i]), 64'(exp_seq[i]));
        end

        // Product corner values; ptr starts at 0 here.
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_op(1, 32'h0001_0000, 32'h0001_0000);
        drive(1'b1, 4'b0001);
        tick();
        drive(1'b1, 4'b0010);
        tick();
        drive(1'b1, 4'b0000);
        repeat (3) tick();
        @(negedge clk);
        chk("s3_max_product", resp_product, 64'hFFFF_FFFE_0000_0001);
        tick();
        @(negedge clk);
        chk("s3_pow_product", resp_product, 64'h0000_0001_0000_0000);
        tick();

        // ptr is now 2; valid 1010 grants 3 then 1, then arb_en drops.
        set_op(3, 32'd7, 32'd9);
        set_op(1, 32'd100, 32'd200);
        drive(1'b1, 4'b1010);
        @(negedge clk);
        chk("s4_grant_first", 64'(req_ready), 64'b1000);
        tick();
        drive(1'b1, 4'b0010);
        @(negedge clk);
        chk("s4_grant_second", 64'(req_ready), 64'b0010);
        tick();
        drive(1'b0, 4'b0101);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("s4_ready_blocked", 64'(req_ready), 64'd0);
            chk("s4_busy_tail", 64'(busy), (k <= 5) ? 64'd1 : 64'd0);
            tick();
        end
        drive(1'b0, 4'b0000);

        // Reset with three operations in flight.
        drive(1'b1, 4'b1111);
        repeat (3) tick();
        drive(1'b1, 4'b0000);
        repeat (2) tick();
        pulse_reset(2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("s5_no_resp", 64'(resp_valid), 64'd0);
            tick();
        end
        drive(1'b1, 4'b1111);
        @(negedge clk);
        chk("s5_ptr_zero", 64'(req_ready), 64'h1);
        tick();
        drive(1'b1, 4'b0000);
        repeat (7) tick();

`ifdef MUL_ARB_STATS_EN
        pulse_reset(1);
        drive(1'b1, 4'b1000);
        repeat (10) tick();
        drive(1'b1, 4'b0000);
        @(negedge clk);
        chk("cnt3", 64'(grant_cnt[3*32 +: 32]), 64'd10);
        chk("cnt0", 64'(grant_cnt[0 +: 32]), 64'd0);
        chk("cnt1", 64'(grant_cnt[32 +: 32]), 64'd0);
        chk("cnt2", 64'(grant_cnt[64 +: 32]), 64'd0);
        repeat (7) tick();
`endif

        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
